// File: rtl/spi_pkg.sv
// Shared constants, FIFO entry type and status-word packing for the SPI slave receiver.
package spi_pkg;

  localparam logic SPI_DATA = 1'b1;
  localparam logic SPI_CMD  = 1'b0;

  localparam int unsigned SPI_BITS = 8;

  localparam int unsigned RD_VALID   = 31;
  localparam int unsigned RD_OVR     = 30;
  localparam int unsigned RD_FERR    = 29;
  localparam int unsigned RD_LVL_LSB = 24;
  localparam int unsigned RD_LVL_W   = 4;
  localparam int unsigned RD_DC      = 8;

  // CPOL=1: sck idles high, data changes on the falling edge and is sampled on the rising edge
  localparam logic CPOL = 1'b1;

  typedef struct packed {
    logic                dc;
    logic [SPI_BITS-1:0] data;
  } spi_entry_t;

  // Head fields are forced to zero when the FIFO is empty
  function automatic logic [31:0] pack_rdata(input logic                valid,
                                             input logic                ovr,
                                             input logic                ferr,
                                             input logic [RD_LVL_W-1:0] lvl,
                                             input spi_entry_t          head);
    logic [31:0] w;
    w = '0;
    w[RD_VALID] = valid;
    w[RD_OVR]   = ovr;
    w[RD_FERR]  = ferr;
    w[RD_LVL_LSB +: RD_LVL_W] = lvl;
    if (valid) begin
      w[RD_DC]          = head.dc;
      w[SPI_BITS-1:0]   = head.data;
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous FIFO of {dc, byte} entries; a pop frees a slot for a same-cycle push when full.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = 3
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          push,
  input  logic          pop,
  input  spi_entry_t    din,
  output spi_entry_t    dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = LW - 1;

  spi_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);
  assign dout      = r_mem[r_rd_ptr];
  assign level     = r_level;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; empty entries are masked downstream
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_rx.sv
// SPI slave receiver (CPOL=1, MSB first): oversamples the pins, assembles bytes with their
// D/C qualifier into a FIFO and presents head entry plus status as a registered CPU word.
module spi_rx
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = 3
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        sck_in,
  input  logic        cs_in_,
  input  logic        sdi,
  input  logic        dc_in,
  input  logic        pop,
  input  logic        clr,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned CW = $clog2(SPI_BITS);

  logic                r_sck_m, r_sck_s, r_sck_d;
  logic                r_cs_m, r_cs_s, r_cs_d;
  logic                r_sdi_m, r_sdi_s;
  logic                r_dc_m, r_dc_s;
  logic [CW-1:0]       r_cnt;
  logic [SPI_BITS-2:0] r_shift;
  logic                r_ovr;
  logic                r_ferr;

  logic                w_sck_rise;
  logic                w_cs_fall;
  logic                w_cs_rise;
  logic                w_capture;
  logic                w_push;
  logic                w_ferr_evt;
  logic                w_ovr_evt;
  spi_entry_t          w_push_data;
  spi_entry_t          w_head;
  logic [LW-1:0]       w_level;
  logic                w_full;
  logic                w_empty;

  // Two-flop synchronizers plus a delayed copy for edge detection; reset to idle pin levels
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_sck_m <= CPOL;  r_sck_s <= CPOL;  r_sck_d <= CPOL;
      r_cs_m  <= 1'b1;  r_cs_s  <= 1'b1;  r_cs_d  <= 1'b1;
      r_sdi_m <= 1'b0;  r_sdi_s <= 1'b0;
      r_dc_m  <= 1'b0;  r_dc_s  <= 1'b0;
    end else begin
      r_sck_m <= sck_in;  r_sck_s <= r_sck_m;  r_sck_d <= r_sck_s;
      r_cs_m  <= cs_in_;  r_cs_s  <= r_cs_m;   r_cs_d  <= r_cs_s;
      r_sdi_m <= sdi;     r_sdi_s <= r_sdi_m;
      r_dc_m  <= dc_in;   r_dc_s  <= r_dc_m;
    end
  end

  assign w_sck_rise  = r_sck_s & ~r_sck_d;
  assign w_cs_fall   = ~r_cs_s & r_cs_d;
  assign w_cs_rise   = r_cs_s & ~r_cs_d;
  assign w_capture   = w_sck_rise & ~r_cs_s & ~w_cs_fall;
  assign w_push      = w_capture & (r_cnt == CW'(SPI_BITS - 1));
  assign w_push_data = '{dc: r_dc_s, data: {r_shift, r_sdi_s}};
  assign w_ferr_evt  = w_cs_rise & (r_cnt != '0);
  // Full implies non-empty, so a coincident pop always makes room
  assign w_ovr_evt   = w_push & w_full & ~pop;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_cs_fall) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_cs_rise) begin
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_shift <= {r_shift[SPI_BITS-3:0], r_sdi_s};
      r_cnt   <= w_push ? '0 : r_cnt + CW'(1);
    end
  end

  // A new error event outranks a same-cycle clear
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_evt  | (r_ovr  & ~clr);
      r_ferr <= w_ferr_evt | (r_ferr & ~clr);
    end
  end

  spi_rx_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk    (clk),
    .reset_ (reset_),
    .push   (w_push),
    .pop    (pop),
    .din    (w_push_data),
    .dout   (w_head),
    .level  (w_level),
    .full   (w_full),
    .empty  (w_empty)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      rdata <= pack_rdata(~w_empty, r_ovr, r_ferr, RD_LVL_W'(w_level), w_head);
      irq   <= ~w_empty;
    end
  end

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: table of single frames plus hand-written multi-cycle scenarios,
// with a queue model of the FIFO supplying expected status words.
module tb_spi_rx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;
  localparam int          HALF  = 25;

  logic        clk = 1'b0;
  logic        reset_;
  logic        sck_in;
  logic        cs_in_;
  logic        sdi;
  logic        dc_in;
  logic        pop;
  logic        clr;
  logic [31:0] rdata;
  logic        irq;

  always #8 clk = ~clk;

  spi_rx #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .sck_in (sck_in),
    .cs_in_ (cs_in_),
    .sdi    (sdi),
    .dc_in  (dc_in),
    .pop    (pop),
    .clr    (clr),
    .rdata  (rdata),
    .irq    (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] sb[$];
  logic       m_ovr;
  logic       m_ferr;

  typedef struct {
    logic        dc;
    logic [7:0]  data;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    w = '0;
    w[31] = (sb.size() != 0);
    w[30] = m_ovr;
    w[29] = m_ferr;
    w[27:24] = 4'(sb.size());
    if (sb.size() != 0) w[8:0] = sb[0];
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic dc, input logic [7:0] d);
    if (sb.size() == DEPTH) m_ovr = 1'b1;
    else sb.push_back({dc, d});
  endtask

  // Sends d[n-1:0] MSB first, ending with sck high
  task automatic shift_bits(input logic dc, input logic [7:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sck_in = 1'b0;
      sdi    = d[i];
      dc_in  = dc;
      wait_clk(HALF);
      sck_in = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic frame(input logic dc, input logic [7:0] d);
    cs_in_ = 1'b0;
    wait_clk(HALF);
    shift_bits(dc, d, 8);
    model_push(dc, d);
    cs_in_ = 1'b1;
    wait_clk(HALF);
  endtask

  // Frame whose status word must appear within 5 clk of the 8th rising sck edge
  task automatic frame_lat(input logic dc, input logic [7:0] d, input logic [31:0] exp);
    logic found;
    cs_in_ = 1'b0;
    wait_clk(HALF);
    shift_bits(dc, d >> 1, 7);
    sck_in = 1'b0;
    sdi    = d[0];
    wait_clk(HALF);
    sck_in = 1'b1;
    found  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_clk(1);
      if (rdata[31]) begin
        found = 1'b1;
        break;
      end
    end
    chk("latency_valid", 32'(found), 32'd1);
    chk("frame_word", rdata, exp);
    chk("frame_irq", 32'(irq), 32'd1);
    wait_clk(HALF);
    model_push(dc, d);
    cs_in_ = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic pop_chk(input string name);
    chk(name, rdata, exp_word());
    chk({name, "_irq"}, 32'(irq), 32'(sb.size() != 0));
    pop = 1'b1;
    wait_clk(1);
    pop = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
    wait_clk(2);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    wait_clk(1);
    clr = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    #1_600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{dc: 1'b0, data: 8'hA5, exp: 32'h810000A5};
    vecs[1] = '{dc: 1'b1, data: 8'h3C, exp: 32'h8100013C};
    vecs[2] = '{dc: 1'b0, data: 8'h00, exp: 32'h81000000};
    vecs[3] = '{dc: 1'b1, data: 8'hFF, exp: 32'h810001FF};
    vecs[4] = '{dc: 1'b0, data: 8'h5A, exp: 32'h8100005A};

    reset_ = 1'b0;
    sck_in = 1'b1;
    cs_in_ = 1'b1;
    sdi    = 1'b0;
    dc_in  = 1'b0;
    pop    = 1'b0;
    clr    = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    wait_clk(3);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'd0);
    reset_ = 1'b1;
    wait_clk(3);
    chk("idle_rdata", rdata, 32'h0);

    // Single frames from the table, each popped back out
    foreach (vecs[i]) begin
      frame_lat(vecs[i].dc, vecs[i].data, vecs[i].exp);
      pop_chk("tbl_pop");
      chk("tbl_empty_rdata", rdata, 32'h0);
      chk("tbl_empty_irq", 32'(irq), 32'd0);
    end

    // Empty pop has no effect
    pop = 1'b1;
    wait_clk(1);
    pop = 1'b0;
    wait_clk(2);
    chk("empty_pop", rdata, 32'h0);

    // Two bytes in one chip-select window
    cs_in_ = 1'b0;
    wait_clk(HALF);
    shift_bits(1'b1, 8'h3C, 8);
    model_push(1'b1, 8'h3C);
    chk("multi_first", rdata, 32'h8100013C);
    shift_bits(1'b0, 8'hC3, 8);
    model_push(1'b0, 8'hC3);
    chk("multi_level2", rdata, 32'h8200013C);
    cs_in_ = 1'b1;
    wait_clk(HALF);
    pop_chk("multi_pop0");
    chk("multi_second", rdata, 32'h810000C3);
    pop_chk("multi_pop1");

    // Overrun: five frames into a four-entry FIFO
    for (int v = 1; v <= 5; v++) frame(1'b0, 8'(v));
    chk("ovr_word", rdata, 32'hC4000001);
    for (int v = 1; v <= 4; v++) pop_chk("ovr_pop");
    chk("ovr_drained", rdata, 32'h40000000);
    clr_pulse();
    chk("ovr_clr", rdata, 32'h0);

    // Framing error: cs_ raised after 5 bits
    cs_in_ = 1'b0;
    wait_clk(HALF);
    shift_bits(1'b0, 8'h16, 5);
    cs_in_ = 1'b1;
    m_ferr = 1'b1;
    wait_clk(HALF);
    chk("ferr_only", rdata, 32'h20000000);
    frame(1'b0, 8'h81);
    chk("ferr_word", rdata, 32'hA1000081);
    pop_chk("ferr_pop");
    clr_pulse();
    chk("ferr_clr", rdata, 32'h0);

    // Reset in the middle of a frame
    cs_in_ = 1'b0;
    wait_clk(HALF);
    shift_bits(1'b1, 8'h0C, 4);
    reset_ = 1'b0;
    #2;
    chk("midreset_rdata", rdata, 32'h0);
    chk("midreset_irq", 32'(irq), 32'd0);
    wait_clk(2);
    reset_ = 1'b1;
    sb.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    wait_clk(2);
    cs_in_ = 1'b1;
    wait_clk(HALF);
    chk("postreset_idle", rdata, 32'h0);
    frame(1'b0, 8'h5A);
    chk("postreset_word", rdata, 32'h8100005A);
    pop_chk("postreset_pop");

    // Full FIFO with pop coincident with the push of 0x77
    for (int v = 0; v < 4; v++) frame(1'b0, 8'(8'h10 + v));
    chk("full_word", rdata, 32'h84000010);
    cs_in_ = 1'b0;
    wait_clk(HALF);
    shift_bits(1'b0, 8'h3B, 7);
    sck_in = 1'b0;
    sdi    = 1'b1;
    wait_clk(HALF);
    sck_in = 1'b1;
    wait_clk(2);
    pop = 1'b1;
    wait_clk(1);
    pop = 1'b0;
    void'(sb.pop_front());
    sb.push_back({1'b0, 8'h77});
    wait_clk(HALF);
    chk("coinc_word", rdata, 32'h84000011);
    cs_in_ = 1'b1;
    wait_clk(HALF);
    for (int v = 0; v < 3; v++) pop_chk("coinc_pop");
    chk("coinc_last", rdata, 32'h81000077);
    pop_chk("coinc_pop_last");
    chk("coinc_empty", rdata, 32'h0);
    chk("coinc_irq", 32'(irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
